// File: rtl/uart_rx.sv
// UART receiver: synchronizes the idle-high serial line, deframes start/data/stop
// bits (LSB first) and presents each good word on a one-deep AXI-Stream register.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_wire,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_PERIOD / 2;
  localparam int CNT_W      = $clog2(BIT_PERIOD);
  localparam int BIT_W      = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic       rx_m, rx_s, rx_d;
  logic [1:0] live;
  logic       armed;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  shift_en;
  logic                  vld_d, ok_d;
  logic                  vld_p0, ok_p0;
  logic                  load, drop, bad;

  // Synchronizer; live marks when rx_s reflects the line rather than its reset value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
      live  <= 2'b00;
      armed <= 1'b0;
    end else begin
      rx_m <= rx_wire;
      rx_s <= rx_m;
      rx_d <= rx_s;
      live <= {live[0], 1'b1};
      if (live[1] && rx_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      vld_p0  <= 1'b0;
      ok_p0   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      vld_p0  <= vld_d;
      ok_p0   <= ok_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_en = 1'b0;
    vld_d    = 1'b0;
    ok_d     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (armed && rx_d && !rx_s) state_d = START;
      end
      START: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_q == HALF_END) begin
          baud_d  = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_q == BIT_END) begin
          baud_d   = '0;
          shift_en = 1'b1;
          bit_d    = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_q == BIT_END) begin
          baud_d  = '0;
          state_d = IDLE;
          vld_d   = 1'b1;
          ok_d    = rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: completed word from vld_p0 meets the AXI-Stream register
  assign load = vld_p0 && ok_p0 && (!m_axis_tvalid || m_axis_tready);
  assign drop = vld_p0 && ok_p0 && m_axis_tvalid && !m_axis_tready;
  assign bad  = vld_p0 && !ok_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      m_axis_tvalid <= load || (m_axis_tvalid && !m_axis_tready);
      if (load) m_axis_tdata <= shift_q;
      frame_err <= bad;
      overrun   <= drop;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BIT_PERIOD=10: table vectors, hand-written corner sequences,
// and random frames checked against a line-level UART decoder model.
module tb_uart_rx;

  localparam int BIT  = 10;
  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_wire = 1'b1;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready = 1'b1;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_wire(rx_wire),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // kind: 0 = word handshake, 1 = frame error, 2 = overrun
  typedef struct packed {logic [1:0] kind; logic [7:0] data;} ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [1:0] exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic line_q[$];
  ev_t  got_q[$];
  ev_t  exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line as seen by the receiver's first flop, one entry per clock edge
  always @(posedge clk) begin
    if (rst) line_q.push_back(rx_wire);
    else line_q.delete();
  end

  always @(negedge clk) begin
    if (rst) begin
      if (frame_err && overrun) check("ferr_ovr_exclusive", 32'd1, 32'd0);
      if (tvalid && tready) got_q.push_back({2'd0, tdata});
      if (frame_err) got_q.push_back({2'd1, 8'h00});
      if (overrun) got_q.push_back({2'd2, 8'h00});
    end
  end

  // Reference decoder: find a 1->0 edge, validate start mid-bit, sample each bit
  // one period apart, then resume hunting just after the last sample taken.
  function automatic void model_expect();
    int i;
    int f;
    int n;
    logic [7:0] w;
    n = line_q.size();
    i = 2;
    while (i < n) begin
      if (line_q[i-1] == 1'b1 && line_q[i] == 1'b0) begin
        f = i;
        if (f + HALF + 9 * BIT >= n) break;
        if (line_q[f + HALF] == 1'b1) begin
          i = f + HALF + 1;
          continue;
        end
        for (int k = 0; k < 8; k++) w[k] = line_q[f + HALF + BIT * (k + 1)];
        if (line_q[f + HALF + 9 * BIT]) exp_q.push_back({2'd0, w});
        else exp_q.push_back({2'd1, 8'h00});
        i = f + HALF + 9 * BIT + 1;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic compare_events(input string name);
    int n;
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", name, i), {22'd0, got_q[i]}, {22'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
    line_q.delete();
  endtask

  task automatic flush();
    got_q.delete();
    exp_q.delete();
    line_q.delete();
  endtask

  // All drive tasks start and end 1 time unit after a rising edge
  task automatic hold(input logic v, input int n);
    rx_wire = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold(1'b0, BIT);
    for (int k = 0; k < 8; k++) hold(d[k], BIT);
    hold(stop, BIT);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] rd;
    logic       rs;
    int         gap;

    vecs[0] = '{8'hA5, 1'b1, 2'd0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 2'd0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 2'd0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b1, 2'd0, 8'h3C};
    vecs[4] = '{8'h55, 1'b0, 2'd1, 8'h00};
    vecs[5] = '{8'h81, 1'b1, 2'd0, 8'h81};
    vecs[6] = '{8'h7E, 1'b0, 2'd1, 8'h00};
    vecs[7] = '{8'h01, 1'b1, 2'd0, 8'h01};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    hold(1'b1, 20);

    // Single frame latency: 3 edges to START, then 1+5+90
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 1; k <= 200; k++) begin
          @(posedge clk);
          #1;
          if (tvalid) begin
            lat = k;
            break;
          end
        end
      end
    join
    check("a5_latency", lat, 99);
    check("a5_tdata", tdata, 8'hA5);
    hold(1'b1, 1);
    check("a5_tvalid_drop", tvalid, 0);
    hold(1'b1, 30);
    model_expect();
    compare_events("a5_model");

    // Table vectors
    foreach (vecs[v]) begin
      hold(1'b1, 4);
      send_frame(vecs[v].data, vecs[v].stop);
      hold(1'b1, 30);
      check($sformatf("vec%0d_count", v), got_q.size(), 1);
      if (got_q.size() >= 1)
        check($sformatf("vec%0d_event", v), {22'd0, got_q[0]},
              {22'd0, vecs[v].exp_kind, vecs[v].exp_data});
      flush();
    end

    // Back-to-back frames, stop bit exactly one period
    hold(1'b1, 4);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 30);
    exp_q.push_back({2'd0, 8'h00});
    exp_q.push_back({2'd0, 8'hFF});
    exp_q.push_back({2'd0, 8'h3C});
    compare_events("loopback");

    // Glitches: a short low pulse is rejected, a frame right after it is received
    hold(1'b1, 4);
    hold(1'b0, 3);
    hold(1'b1, 100);
    check("glitch_tvalid", tvalid, 0);
    hold(1'b0, 3);
    hold(1'b1, 5);
    send_frame(8'h96, 1'b1);
    hold(1'b1, 30);
    model_expect();
    compare_events("glitch");

    // Framing error followed by a held break
    hold(1'b1, 4);
    send_frame(8'h55, 1'b0);
    hold(1'b0, 50);
    check("break_tvalid", tvalid, 0);
    hold(1'b1, 30);
    send_frame(8'h3A, 1'b1);
    hold(1'b1, 30);
    exp_q.push_back({2'd1, 8'h00});
    exp_q.push_back({2'd0, 8'h3A});
    compare_events("break");

    // Overrun with downstream stalled
    tready = 1'b0;
    hold(1'b1, 4);
    send_frame(8'h11, 1'b1);
    hold(1'b1, 10);
    check("ovr_first_tvalid", tvalid, 1);
    check("ovr_first_tdata", tdata, 8'h11);
    send_frame(8'h22, 1'b1);
    hold(1'b1, 10);
    check("ovr_held_tvalid", tvalid, 1);
    check("ovr_held_tdata", tdata, 8'h11);
    tready = 1'b1;
    hold(1'b1, 1);
    check("ovr_drain_tvalid", tvalid, 0);
    hold(1'b1, 10);
    exp_q.push_back({2'd2, 8'h00});
    exp_q.push_back({2'd0, 8'h11});
    compare_events("overrun");

    // Reset mid-DATA with the line held low through release
    hold(1'b1, 4);
    hold(1'b0, 45);
    rst = 1'b0;
    #1;
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_tdata", tdata, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    hold(1'b0, 150);
    check("post_rst_tvalid", tvalid, 0);
    hold(1'b1, 20);
    send_frame(8'hE7, 1'b1);
    hold(1'b1, 30);
    model_expect();
    compare_events("reset");

    // Random frames, gaps and stop bits
    hold(1'b1, 4);
    for (int r = 0; r < 40; r++) begin
      rd  = 8'($urandom);
      rs  = ($urandom_range(0, 7) != 0);
      gap = $urandom_range(0, 12);
      if (!rs && gap == 0) gap = 1;
      send_frame(rd, rs);
      if (gap > 0) hold(1'b1, gap);
    end
    hold(1'b1, 120);
    model_expect();
    compare_events("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
